// File: rtl/main_memory_responder.sv
// Terminal memory model: answers nextlevel READ/RFO/WRITE line transfers after a fixed
// latency and can force back-invalidation of one line in the cache above.

package cachepkg;
  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RFO   = 2'd3
  } op_t;
endpackage

module main_memory_responder
  import cachepkg::*;
#(
  parameter int                   ADDRWIDTH     = 32,
  parameter int                   DATAWIDTH     = 32,
  parameter int                   LINEITEMS     = 64,
  parameter int                   DEPTH         = 1024,
  parameter int                   LATENCY       = 4,
  parameter int                   EVICT_TIMEOUT = 8,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN  = 32'hDEADBEEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           request,
  input  op_t                            operation,
  input  logic [ADDRWIDTH-1:0]           addr_in,
  input  logic [LINEITEMS*DATAWIDTH-1:0] d_in,
  output logic [LINEITEMS*DATAWIDTH-1:0] d_out,
  output logic                           valid,
  output logic                           evict,
  output logic [ADDRWIDTH-1:0]           addr_out,
  input  logic                           evict_req,
  input  logic [ADDRWIDTH-1:0]           evict_addr
);

  localparam int LW  = LINEITEMS * DATAWIDTH;
  localparam int OFF = $clog2(LW / 8);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int TW  = (EVICT_TIMEOUT < 2) ? 1 : $clog2(EVICT_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  op_t             op_q;
  logic [IW-1:0]   idx_q;
  logic [LW-1:0]   data_q;
  logic [LW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [TW-1:0]   timer;

  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   evict_idx;
  logic            op_legal;
  op_t             op_in;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [LW-1:0]   wr_data;
  logic            wb_hit;
  logic            unused_bits;

  assign req_idx     = addr_in[OFF+IW-1:OFF];
  assign evict_idx   = addr_out[OFF+IW-1:OFF];
  assign op_legal    = operation inside {NOP, READ, WRITE, RFO};
  assign op_in       = op_legal ? operation : NOP;
  assign wb_hit      = evict && (state == RESPOND) && (op_q == WRITE) && (idx_q == evict_idx);
  assign unused_bits = ^{addr_in[OFF-1:0], addr_in[ADDRWIDTH-1:OFF+IW], evict_addr[OFF-1:0]};

  // A WRITE commits on the edge that enters RESPOND; with zero latency that is the
  // capture edge itself, so the store is fed straight from the request inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = data_q;
    if (reset) begin
      if (state == IDLE && request && LATENCY == 0) begin
        wr_en   = (op_in == WRITE);
        wr_idx  = req_idx;
        wr_data = d_in;
      end else if (state == BUSY && cnt <= CW'(1)) begin
        wr_en = (op_q == WRITE);
      end
    end
  end

  // NOTE: the line store has no reset; clearing the written bits is enough to make
  // every line read back as INIT_PATTERN after reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= NOP;
      idx_q   <= '0;
      data_q  <= '0;
      written <= '0;
      valid   <= 1'b0;
      d_out   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            op_q   <= op_in;
            idx_q  <= req_idx;
            data_q <= d_in;
            cnt    <= CW'(LATENCY);
            state  <= (LATENCY == 0) ? RESPOND : BUSY;
          end
        end
        BUSY: begin
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= RESPOND;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESPOND: begin
          valid <= 1'b1;
          state <= DRAIN;
          if (op_q == READ || op_q == RFO)
            d_out <= written[idx_q] ? mem[idx_q] : {LINEITEMS{INIT_PATTERN}};
          else if (op_q == NOP)
            d_out <= '0;
        end
        DRAIN: begin
          // A request still held here belongs to the finished transfer.
          if (!request) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wr_en) written[wr_idx] <= 1'b1;
    end
  end

  // Back-invalidation: a matching writeback wins over both the timeout and a new request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evict    <= 1'b0;
      addr_out <= '0;
      timer    <= '0;
    end else if (evict) begin
      if (wb_hit) begin
        evict <= 1'b0;
        timer <= '0;
      end else if (state == IDLE) begin
        if (timer <= TW'(1)) begin
          evict <= 1'b0;
          timer <= '0;
        end else begin
          timer <= timer - TW'(1);
        end
      end
    end else if (evict_req) begin
      evict    <= 1'b1;
      addr_out <= {evict_addr[ADDRWIDTH-1:OFF], {OFF{1'b0}}};
      timer    <= TW'(EVICT_TIMEOUT);
    end
  end

  op_legal_a: assert property (@(posedge clock) disable iff (!reset)
                               (state == IDLE && request) |-> op_legal)
    else $error("main_memory_responder: illegal operation %0d, handled as NOP", operation);

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: vector table, hand-written handshake/eviction/reset
// sequences and a randomized run against a line-level reference model.

module tb_main_memory_responder;
  import cachepkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          LI   = 64;
  localparam int          LW   = LI * DW;
  localparam int          LAT  = 4;
  localparam int          ETO  = 8;
  localparam logic [31:0] INIT = 32'hDEADBEEF;

  localparam int K_NONE = 0;
  localparam int K_INIT = 1;
  localparam int K_RAMP = 2;
  localparam int K_ZERO = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          request = 1'b0;
  op_t           operation = NOP;
  logic [AW-1:0] addr_in = '0;
  logic [LW-1:0] d_in = '0;
  logic [LW-1:0] d_out;
  logic          valid;
  logic          evict;
  logic [AW-1:0] addr_out;
  logic          evict_req = 1'b0;
  logic [AW-1:0] evict_addr = '0;

  logic          request0 = 1'b0;
  op_t           operation0 = NOP;
  logic [AW-1:0] addr_in0 = '0;
  logic [LW-1:0] d_in0 = '0;
  logic [LW-1:0] d_out0;
  logic          valid0;
  logic          evict0;
  logic [AW-1:0] addr_out0;
  logic          evict_req0 = 1'b0;
  logic [AW-1:0] evict_addr0 = '0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    op_t         op;
    logic [31:0] addr;
    logic [31:0] wbase;
    int          kind;
    logic [31:0] ebase;
  } vec_t;

  vec_t vecs[9];
  logic [LW-1:0] model [int];

  main_memory_responder #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .LINEITEMS(LI), .DEPTH(1024),
    .LATENCY(LAT), .EVICT_TIMEOUT(ETO), .INIT_PATTERN(INIT)
  ) dut (
    .clock(clock), .reset(reset), .request(request), .operation(operation),
    .addr_in(addr_in), .d_in(d_in), .d_out(d_out), .valid(valid), .evict(evict),
    .addr_out(addr_out), .evict_req(evict_req), .evict_addr(evict_addr)
  );

  main_memory_responder #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .LINEITEMS(LI), .DEPTH(1024),
    .LATENCY(0), .EVICT_TIMEOUT(ETO), .INIT_PATTERN(INIT)
  ) dut0 (
    .clock(clock), .reset(reset), .request(request0), .operation(operation0),
    .addr_in(addr_in0), .d_in(d_in0), .d_out(d_out0), .valid(valid0), .evict(evict0),
    .addr_out(addr_out0), .evict_req(evict_req0), .evict_addr(evict_addr0)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    int k;
    n_vec++;
    if (got !== exp) begin
      k = 0;
      while (k < LI - 1 && got[k*DW +: DW] === exp[k*DW +: DW]) k++;
      n_bad++;
      $display("FAIL %s: item %0d got %h expected %h", name, k, got[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  function automatic logic [LW-1:0] ramp(input logic [31:0] base);
    logic [LW-1:0] r;
    for (int k = 0; k < LI; k++) r[k*DW +: DW] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [LW-1:0] init_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LI; k++) r[k*DW +: DW] = INIT;
    return r;
  endfunction

  function automatic logic [LW-1:0] expect_line(input int kind, input logic [31:0] base);
    if (kind == K_INIT) return init_line();
    if (kind == K_RAMP) return ramp(base);
    return '0;
  endfunction

  // One full transfer on the main instance; inputs are scrambled after capture.
  task automatic run_xfer(input op_t op, input logic [31:0] addr, input logic [LW-1:0] data,
                          input int ereq_at, input logic [31:0] ereq_addr,
                          output logic [LW-1:0] got, output int lat,
                          output logic ev_pre, output logic ev_at);
    request = 1'b1; operation = op; addr_in = addr; d_in = data;
    step();
    operation = op_t'(2'($urandom_range(0, 3)));
    addr_in   = addr ^ 32'h0001_0300;
    d_in      = ~data;
    lat    = 0;
    ev_pre = evict;
    while (!valid && lat < 50) begin
      ev_pre = evict;
      if (lat == ereq_at) begin
        evict_req = 1'b1; evict_addr = ereq_addr;
      end
      step();
      evict_req = 1'b0;
      lat++;
    end
    got   = d_out;
    ev_at = evict;
    request = 1'b0;
    step();
  endtask

  task automatic run_xfer0(input op_t op, input logic [31:0] addr, input logic [LW-1:0] data,
                           output logic [LW-1:0] got, output int lat);
    request0 = 1'b1; operation0 = op; addr_in0 = addr; d_in0 = data;
    step();
    operation0 = NOP; addr_in0 = ~addr; d_in0 = ~data;
    lat = 0;
    while (!valid0 && lat < 50) begin
      step();
      lat++;
    end
    got = d_out0;
    request0 = 1'b0;
    step();
  endtask

  initial begin
    logic [LW-1:0] got;
    int            lat;
    int            extra;
    logic          ev_pre;
    logic          ev_at;

    vecs[0] = '{"unwritten_read", READ,  32'h0000_1000, 32'h0,         K_INIT, 32'h0};
    vecs[1] = '{"write_line3",    WRITE, 32'h0000_0300, 32'h0,         K_NONE, 32'h0};
    vecs[2] = '{"rfo_line3",      RFO,   32'h0000_0300, 32'h0,         K_RAMP, 32'h0};
    vecs[3] = '{"alias_read",     READ,  32'h0004_0300, 32'h0,         K_RAMP, 32'h0};
    vecs[4] = '{"offset_read",    READ,  32'h0000_03FF, 32'h0,         K_RAMP, 32'h0};
    vecs[5] = '{"nop_zero",       NOP,   32'h0000_0300, 32'h0,         K_ZERO, 32'h0};
    vecs[6] = '{"write_top",      WRITE, 32'h00FF_FF00, 32'h1000_0000, K_NONE, 32'h0};
    vecs[7] = '{"read_top_alias", READ,  32'h0003_FF00, 32'h0,         K_RAMP, 32'h1000_0000};
    vecs[8] = '{"unwritten_line4", READ, 32'h0000_0400, 32'h0,         K_INIT, 32'h0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", valid, 0);
    check("reset_evict", evict, 0);
    check("reset_addr_out", addr_out, 0);
    check_line("reset_d_out", d_out, '0);
    check("reset_valid0", valid0, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].op, vecs[i].addr, ramp(vecs[i].wbase), -1, 32'h0, got, lat, ev_pre, ev_at);
      check($sformatf("%s_latency", vecs[i].name), lat, LAT + 1);
      if (vecs[i].kind != K_NONE)
        check_line($sformatf("%s_data", vecs[i].name), got, expect_line(vecs[i].kind, vecs[i].ebase));
    end

    // Request held long after valid must not start a second transfer.
    request = 1'b1; operation = READ; addr_in = 32'h0000_0300;
    step();
    lat = 0;
    while (!valid && lat < 50) begin step(); lat++; end
    check("hold_latency", lat, LAT + 1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid) extra++;
    end
    check("hold_single_valid", extra, 0);
    check_line("hold_d_out", d_out, ramp(32'h0));
    request = 1'b0;
    step();
    run_xfer(READ, 32'h0000_1000, '0, -1, 32'h0, got, lat, ev_pre, ev_at);
    check("after_hold_latency", lat, LAT + 1);
    check_line("after_hold_data", got, init_line());

    // Zero-latency instance, including a write fed straight from the inputs.
    run_xfer0(READ, 32'h0000_1000, '0, got, lat);
    check("lat0_read_latency", lat, 1);
    check_line("lat0_read_data", got, init_line());
    check("lat0_valid_drop", valid0, 0);
    run_xfer0(WRITE, 32'h0000_0500, ramp(32'h55), got, lat);
    check("lat0_write_latency", lat, 1);
    run_xfer0(READ, 32'h0000_0500, '0, got, lat);
    check_line("lat0_readback", got, ramp(32'h55));

    // Eviction cleared by writeback; a new evict_req on the clearing edge is dropped.
    evict_req = 1'b1; evict_addr = 32'h0000_40A5;
    step();
    evict_req = 1'b0;
    check("evict_raised", evict, 1);
    check("evict_addr_out", addr_out, 32'h0000_4000);
    run_xfer(WRITE, 32'h0000_4000, ramp(32'h4000), LAT, 32'h0000_9000, got, lat, ev_pre, ev_at);
    check("wb_latency", lat, LAT + 1);
    check("wb_evict_before_valid", ev_pre, 1);
    check("wb_evict_at_valid", ev_at, 0);
    check("wb_new_req_dropped", evict, 0);
    check("wb_addr_out_kept", addr_out, 32'h0000_4000);
    run_xfer(READ, 32'h0000_4000, '0, -1, 32'h0, got, lat, ev_pre, ev_at);
    check_line("wb_readback", got, ramp(32'h4000));

    // Eviction timeout with a second evict_req ignored.
    evict_req = 1'b1; evict_addr = 32'h0000_8000;
    step();
    evict_req = 1'b1; evict_addr = 32'h0000_9000;
    check("to_evict_raised", evict, 1);
    for (int i = 1; i <= ETO; i++) begin
      step();
      evict_req = 1'b0;
      check($sformatf("to_evict_cycle%0d", i), evict, (i < ETO) ? 1 : 0);
      check($sformatf("to_addr_out_cycle%0d", i), addr_out, 32'h0000_8000);
    end

    // Reset during a WRITE in BUSY: outputs clear at once and the write is lost.
    request = 1'b1; operation = WRITE; addr_in = 32'h0000_0600; d_in = ramp(32'h77);
    evict_req = 1'b1; evict_addr = 32'h0000_A000;
    step();
    evict_req = 1'b0;
    check("both_accepted_evict", evict, 1);
    check("both_accepted_addr", addr_out, 32'h0000_A000);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_evict", evict, 0);
    check("rst_addr_out", addr_out, 0);
    check_line("rst_d_out", d_out, '0);
    request = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_xfer(READ, 32'h0000_0600, '0, -1, 32'h0, got, lat, ev_pre, ev_at);
    check("rst_read_latency", lat, LAT + 1);
    check_line("rst_write_lost", got, init_line());
    run_xfer(READ, 32'h0000_0300, '0, -1, 32'h0, got, lat, ev_pre, ev_at);
    check_line("rst_written_cleared", got, init_line());

    // Randomized transfers and evictions against a line-level model.
    for (int t = 0; t < 40; t++) begin
      int            idx;
      int            ev_idx;
      int            gap;
      int            r;
      bit            do_ev;
      bit            hit;
      op_t           op;
      logic [31:0]   a;
      logic [31:0]   ea;
      logic [LW-1:0] wd;
      idx = 500 + int'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFC_0000) | 32'(idx << 8) | ($urandom & 32'h0000_00FF);
      op  = op_t'(2'($urandom_range(0, 3)));
      for (int k = 0; k < LI; k++) wd[k*DW +: DW] = $urandom;
      do_ev  = ($urandom_range(0, 2) == 0);
      gap    = int'($urandom_range(0, 3));
      ev_idx = ($urandom_range(0, 1) == 1) ? idx : 510;
      ea     = ($urandom & 32'hFFFC_0000) | 32'(ev_idx << 8) | ($urandom & 32'h0000_00FF);
      if (do_ev) begin
        evict_req = 1'b1; evict_addr = ea;
        step();
        evict_req = 1'b0;
        check($sformatf("rand%0d_evict_up", t), evict, 1);
        check($sformatf("rand%0d_evict_addr", t), addr_out, ea & 32'hFFFF_FF00);
      end
      repeat (gap) step();
      run_xfer(op, a, wd, -1, 32'h0, got, lat, ev_pre, ev_at);
      check($sformatf("rand%0d_latency", t), lat, LAT + 1);
      if (op == READ || op == RFO)
        check_line($sformatf("rand%0d_read", t), got, model.exists(idx) ? model[idx] : init_line());
      else if (op == NOP)
        check_line($sformatf("rand%0d_nop", t), got, '0);
      else
        model[idx] = wd;
      if (do_ev) begin
        hit = (op == WRITE) && (ev_idx == idx);
        check($sformatf("rand%0d_evict_at_valid", t), ev_at, hit ? 0 : 1);
        if (!hit) begin
          r = ETO - (gap + 1);
          repeat (r - 1) step();
          check($sformatf("rand%0d_evict_held", t), evict, 1);
          step();
          check($sformatf("rand%0d_evict_timeout", t), evict, 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
